// File: rtl/dh_pkg.sv
// dh_pkg: shared FSM/phase/op types and default widths for the DH key sequencer
package dh_pkg;
  localparam int DH_W = 32;
  localparam int DH_EXP_W = 32;
  typedef enum logic [2:0] {IDLE, LOAD, RED, EXP, PUB_OUT, WAIT_PEER, SH_OUT} state_t;
  typedef enum logic {PH_PUB, PH_SHARED} phase_t;
  typedef enum logic {SQR, MUL} op_t;
endpackage

// File: rtl/mod_mul.sv
// mod_mul: z = x*y mod p by MSB-first interleaved shift-add, W+1 cycles go->rdy
//   clk, rst (async, active-low) | go: load x, y | p: modulus, stable during an op
//   rdy: 1-cycle pulse when z is valid | z: product, held until the next go
//   Requires y < p so each step stays below 3p and two subtracts suffice.
module mod_mul #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] p,
  output logic         rdy,
  output logic [W-1:0] z
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]  x_r, y_r;
  logic [W+1:0]  r, t1, t2, t3, pw;
  logic [CW-1:0] cnt;
  logic          run;
  always_comb begin
    pw = {2'b00, p};
    t1 = {r[W:0], 1'b0} + (x_r[W-1] ? {2'b00, y_r} : '0);
    t2 = t1 >= pw ? t1 - pw : t1;
    t3 = t2 >= pw ? t2 - pw : t2;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r <= '0;
      y_r <= '0;
      r   <= '0;
      cnt <= '0;
      run <= 1'b0;
      rdy <= 1'b0;
    end else if (go) begin
      x_r <= x;
      y_r <= y;
      r   <= '0;
      cnt <= CW'(W);
      run <= 1'b1;
      rdy <= 1'b0;
    end else begin
      rdy <= run && cnt == CW'(1);
      if (run) begin
        x_r <= {x_r[W-2:0], 1'b0};
        r   <= t3;
        cnt <= cnt - CW'(1);
        run <= cnt != CW'(1);
      end
    end
  end
  assign z = r[W-1:0];
endmodule

// File: rtl/dh_key_sched.sv
// dh_key_sched: DH sequencer computing A = g^a mod p, then K = B^a mod p on one shared mod_mul
//   clk, rst (async, active-low)
//   start/g/p/a: begin phase 1 (IDLE only) | peer_valid/peer_pub: begin phase 2 (WAIT_PEER only)
//   pub_key/pub_valid: A and its update pulse | shared_key/done: K and its update pulse (done also on err)
//   busy: not IDLE | err: p < 2, sticky until the next accepted start
//   Option DH_CIPHER_EN: adds r_nib (latched with peer_valid) and cipher = shared_key[3:0] ^ r_nib.
module dh_key_sched
  import dh_pkg::*;
#(
  parameter int W     = DH_W,
  parameter int EXP_W = DH_EXP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     g,
  input  logic [W-1:0]     p,
  input  logic [EXP_W-1:0] a,
  input  logic             peer_valid,
  input  logic [W-1:0]     peer_pub,
  output logic [W-1:0]     pub_key,
  output logic             pub_valid,
  output logic [W-1:0]     shared_key,
  output logic             done,
  output logic             busy,
  output logic             err
`ifdef DH_CIPHER_EN
  ,
  input  logic [3:0]       r_nib,
  output logic [3:0]       cipher
`endif
);
  localparam int BW = EXP_W > 1 ? $clog2(EXP_W) : 1;
  state_t         state, nxt;
  phase_t         phase;
  op_t            op;
  logic [W-1:0]   g_r, p_r, peer_r, acc_base, result, mul_x, mul_y, z;
  logic [EXP_W-1:0] a_r;
  logic [BW-1:0]  bit_idx;
  logic           go, rdy, mul_busy, mul_next, last;
`ifdef DH_CIPHER_EN
  logic [3:0]     r_nib_r;
`endif
  mod_mul #(.W(W)) u_mul (
    .clk(clk),
    .rst(rst),
    .go(go),
    .x(mul_x),
    .y(mul_y),
    .p(p_r),
    .rdy(rdy),
    .z(z)
  );
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= nxt;
  end
  // Operands for the next op come straight from z, so chained ops issue on the capture edge.
  // RED either waits on the op LOAD issued (phase 1) or issues the peer reduction itself (phase 2).
  always_comb begin
    nxt      = state;
    go       = 1'b0;
    mul_x    = z;
    mul_y    = z;
    mul_next = op == SQR && a_r[bit_idx];
    last     = bit_idx == '0;
    case (state)
      IDLE:      nxt = start ? LOAD : IDLE;
      LOAD: begin
        nxt   = p_r < W'(2) ? IDLE : RED;
        go    = p_r >= W'(2);
        mul_x = g_r;
        mul_y = W'(1);
      end
      RED: begin
        nxt   = rdy ? EXP : RED;
        go    = !mul_busy || rdy;
        mul_x = mul_busy ? W'(1) : peer_r;
        mul_y = W'(1);
      end
      EXP: begin
        go    = rdy && (mul_next || !last);
        mul_y = mul_next ? acc_base : z;
        nxt   = rdy && !mul_next && last ? (phase == PH_PUB ? PUB_OUT : SH_OUT) : EXP;
      end
      PUB_OUT:   nxt = WAIT_PEER;
      WAIT_PEER: nxt = peer_valid ? RED : WAIT_PEER;
      SH_OUT:    nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_r        <= '0;
      p_r        <= '0;
      a_r        <= '0;
      peer_r     <= '0;
      acc_base   <= '0;
      result     <= '0;
      bit_idx    <= '0;
      op         <= SQR;
      phase      <= PH_PUB;
      mul_busy   <= 1'b0;
      pub_key    <= '0;
      shared_key <= '0;
      pub_valid  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef DH_CIPHER_EN
      r_nib_r    <= '0;
      cipher     <= '0;
`endif
    end else begin
      pub_valid <= 1'b0;
      done      <= 1'b0;
      mul_busy  <= go || (mul_busy && !rdy);
      case (state)
        IDLE: if (start) begin
          g_r   <= g;
          p_r   <= p;
          a_r   <= a;
          phase <= PH_PUB;
        end
        LOAD: begin
          err        <= p_r < W'(2);
          done       <= p_r < W'(2);
          pub_key    <= '0;
          shared_key <= '0;
`ifdef DH_CIPHER_EN
          cipher     <= '0;
`endif
        end
        RED: if (rdy) begin
          acc_base <= z;
          result   <= W'(1);
          bit_idx  <= BW'(EXP_W - 1);
          op       <= SQR;
        end
        EXP: if (rdy) begin
          result <= z;
          op     <= mul_next ? MUL : SQR;
          if (!mul_next && !last) bit_idx <= bit_idx - BW'(1);
        end
        PUB_OUT: begin
          pub_key   <= result;
          pub_valid <= 1'b1;
        end
        WAIT_PEER: if (peer_valid) begin
          peer_r  <= peer_pub;
          phase   <= PH_SHARED;
`ifdef DH_CIPHER_EN
          r_nib_r <= r_nib;
`endif
        end
        SH_OUT: begin
          shared_key <= result;
          done       <= 1'b1;
`ifdef DH_CIPHER_EN
          cipher     <= result[3:0] ^ r_nib_r;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dh_key_sched.sv
// tb_dh_key_sched: scoreboard bench for dh_key_sched (expected keys, latency and err queued at stimulus)
module tb_dh_key_sched;
  import dh_pkg::*;
  localparam int W  = DH_W;
  localparam int EW = DH_EXP_W;
  typedef struct {
    logic         is_done;
    logic [W-1:0] key;
    logic         err_v;
    logic [3:0]   cip;
    int           t0;
    int           lat;
  } exp_t;
  logic clk = 0, rst = 0, start = 0, peer_valid = 0;
  logic [W-1:0] g = 0, p = 0, peer_pub = 0;
  logic [EW-1:0] a = 0;
  logic [W-1:0] pub_key, shared_key;
  logic pub_valid, done, busy, err;
`ifdef DH_CIPHER_EN
  logic [3:0] r_nib = 0, cipher;
`endif
  int n_cmp = 0, n_bad = 0, cyc = 0;
  exp_t exp_q[$];
  logic [EW-1:0] cur_a = 0;
  logic [W-1:0]  cur_p = 0;

  dh_key_sched dut (
    .clk(clk), .rst(rst), .start(start), .g(g), .p(p), .a(a),
    .peer_valid(peer_valid), .peer_pub(peer_pub),
    .pub_key(pub_key), .pub_valid(pub_valid), .shared_key(shared_key),
    .done(done), .busy(busy), .err(err)
`ifdef DH_CIPHER_EN
    , .r_nib(r_nib), .cipher(cipher)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [W-1:0] modpow(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] m);
    logic [63:0] r, x;
    r = 64'd1;
    x = 64'(b) % 64'(m);
    for (int i = 0; i < EW; i++) begin
      if (e[i]) r = (r * x) % 64'(m);
      x = (x * x) % 64'(m);
    end
    return W'(r);
  endfunction

  function automatic int lat_of(input logic [EW-1:0] e);
    return 2 + (1 + EW + $countones(e)) * (W + 1);
  endfunction

  task automatic do_start(input logic [W-1:0] gg, input logic [W-1:0] pp, input logic [EW-1:0] aa, input bit expect_it);
    exp_t e;
    @(negedge clk);
    g = gg; p = pp; a = aa; start = 1;
    if (expect_it) begin
      cur_a = aa; cur_p = pp;
      e.t0 = cyc + 1;
      e.is_done = pp < 2;
      e.key = pp < 2 ? '0 : modpow(gg, aa, pp);
      e.err_v = pp < 2;
      e.cip = 0;
      e.lat = pp < 2 ? 1 : lat_of(aa);
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 0;
  endtask

  task automatic do_peer(input logic [W-1:0] bb, input logic [3:0] nib, input bit expect_it);
    exp_t e;
    @(negedge clk);
    peer_pub = bb; peer_valid = 1;
`ifdef DH_CIPHER_EN
    r_nib = nib;
`endif
    if (expect_it) begin
      e.t0 = cyc + 1;
      e.is_done = 1;
      e.key = modpow(bb, cur_a, cur_p);
      e.err_v = 0;
      e.cip = e.key[3:0] ^ nib;
      e.lat = lat_of(cur_a);
      exp_q.push_back(e);
    end
    @(negedge clk);
    peer_valid = 0;
  endtask

  task automatic wait_q();
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      chk("timeout", 64'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && (pub_valid || done)) begin
      if (exp_q.size() == 0) chk("unexpected", {pub_valid, done}, 0);
      else begin
        e = exp_q.pop_front();
        chk("kind", {pub_valid, done}, e.is_done ? 2'b01 : 2'b10);
        chk("key", done ? shared_key : pub_key, e.key);
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        chk("err", err, e.err_v);
`ifdef DH_CIPHER_EN
        if (done) chk("cipher", cipher, e.cip);
`endif
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_pub_key", pub_key, 0);
    chk("rst_shared", shared_key, 0);
    chk("rst_err", err, 0);
    chk("rst_pulses", {pub_valid, done}, 0);
    @(negedge clk);
    rst = 1;
    do_start(5, 23, 6, 1);
    wait_q();
    chk("pub_key_8", pub_key, 8);
    chk("busy_wait_peer", busy, 1);
    do_peer(19, 4'hA, 1);
    wait_q();
    chk("shared_2", shared_key, 2);
    chk("idle_after", busy, 0);
    do_start(5, 1, 6, 1);
    wait_q();
    #20;
    chk("err_sticky", err, 1);
    chk("err_busy", busy, 0);
    chk("err_pub_clr", pub_key, 0);
    chk("err_sh_clr", shared_key, 0);
    do_start(5, 23, 0, 1);
    wait_q();
    chk("a0_pub", pub_key, 1);
    chk("a0_err_clr", err, 0);
    do_peer(7, 4'h3, 1);
    wait_q();
    do_start(30, 23, 1, 1);
    wait_q();
    chk("base_red", pub_key, 7);
    do_peer(5, 4'h0, 1);
    wait_q();
    do_start(5, 23, 6, 1);
    repeat (200) @(negedge clk);
    do_start(9, 1, 1, 0);
    do_peer(1, 4'hF, 0);
    wait_q();
    chk("ignored_pub", pub_key, 8);
    do_peer(19, 4'h5, 1);
    wait_q();
    do_start(3, 23, 5, 1);
    wait_q();
    do_peer(19, 4'h1, 1);
    repeat (600) @(negedge clk);
    rst = 0;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pub", pub_key, 0);
    chk("mid_rst_sh", shared_key, 0);
    chk("mid_rst_flags", {pub_valid, done, err}, 0);
    @(negedge clk);
    rst = 1;
    do_start(5, 23, 6, 1);
    wait_q();
    do_peer(19, 4'hA, 1);
    wait_q();
    chk("fresh_shared", shared_key, 2);
    for (int k = 0; k < 2; k++) begin
      do_start($urandom, $urandom | 32'h8000_0001, $urandom, 1);
      wait_q();
      do_peer($urandom, 4'($urandom), 1);
      wait_q();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
